tri_port_cam_regfile: RTL and testbench
=======================================

// Module: tri_port_cam_regfile
// PURPOSE
//  Small register file with three independent ports: one synchronous read
//  port, one synchronous write port and one CAM (content search) port.
//  Addresses are decoded, i.e. one bit per entry. Used as a building block
//  for tag arrays, pending-request tables and similar structures in the
//  pipeline and memory subsystem.
// PARAMETERS
//  SINGLE_ENTRY_WIDTH_IN_BITS  default 64  width of one entry in bits
//  NUM_ENTRY                   default 16  number of entries; also the width of the decoded address and CAM result
// PORTS
//  clk_in                       in   1      clock, all state updates on rising edge
//  reset_in                     in   1      asynchronous, active-high reset
//  read_en_in                   in   1      read port enable
//  write_en_in                  in   1      write port enable
//  cam_en_in                    in   1      CAM port enable
//  read_entry_addr_decoded_in   in   NUM_ENTRY  decoded read address
//  write_entry_addr_decoded_in  in   NUM_ENTRY  decoded write mask
//  cam_entry_in                 in   SINGLE_ENTRY_WIDTH_IN_BITS  search key
//  write_entry_in               in   SINGLE_ENTRY_WIDTH_IN_BITS  write data
//  read_entry_out               out  SINGLE_ENTRY_WIDTH_IN_BITS  registered read data
//  cam_result_decoded_out       out  NUM_ENTRY  registered match vector, bit i = entry i matched
// BEHAVIOUR
//  Reset (async, active-high):
//   - all entries, read_entry_out and cam_result_decoded_out are cleared to 0.
//   - reset asserted mid-operation wins immediately; no write completes.
//  Write:
//   - On each edge with write_en_in=1, every entry i with write_entry_addr_decoded_in[i]=1
//     loads write_entry_in.
//   - Multi-bit masks write all selected entries; an all-zero mask is a no-op.
//   - The data is visible to read and CAM from the next edge on.
//  Read:
//   - 1-cycle latency. On an edge with read_en_in=1, read_entry_out <= bitwise OR of all
//     entries whose read_entry_addr_decoded_in bit is set.
//   - With a one-hot address this is the addressed entry; an all-zero address gives 0.
//   - With read_en_in=0, read_entry_out holds its last value.
//  CAM:
//   - 1-cycle latency. On an edge with cam_en_in=1, cam_result_decoded_out[i] <=
//     (entry[i] == cam_entry_in), a full-width compare over all entries in parallel.
//   - With cam_en_in=0, the output holds its last value.
//  Same-edge read/CAM and write:
//   - Read and CAM see the pre-write array contents (old data).
//   - The new data appears from the following enabled access.
//  All three ports operate independently and may be active on the same edge.
//  No X propagation: outputs are always driven from reset state or valid entries.
// TESTING  (W=8, N=4)
//  1. Write 8'hF0 to mask 4'b0001, then read addr 4'b0001 for one cycle
//     -> read_entry_out = 8'hF0.
//  2. Assert read_en and write_en together (data F0, entry 0); drop write_en, then change
//     write data to 8'h0F while still reading -> read_entry_out stays 8'hF0.
//  3. After reset, CAM key 8'hF0 -> cam_result_decoded_out = 4'b0000.
//  4. Write 8'hF0 with mask 4'b1111, CAM key F0 -> 4'b1111.
//  5. Then write 8'h0F with mask 4'b1010, CAM key F0 -> 4'b0101.
//     Reading entry 1 gives 8'h0F.
//  6. Same-edge write (entry 2 = 8'hAA) with read of entry 2 returns the old value;
//     the next read returns 8'hAA. Async reset mid-stream clears both outputs to 0
//     at once.

Source files
------------

// File: rtl/tri_port_cam_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tri_port_cam_regfile
//  Description : Small register file with one synchronous read port, one
//                synchronous write port and one CAM (content search) port.
//                Read/write addresses are decoded (one bit per entry); the
//                CAM result is a decoded match vector. Read and CAM results
//                are registered (1-cycle latency) and observe the array as it
//                was before any write on the same edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tri_port_cam_regfile #(
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
    parameter int NUM_ENTRY                  = 16
) (
    input  logic                                  clk_in,
    input  logic                                  reset_in,
    input  logic                                  read_en_in,
    input  logic                                  write_en_in,
    input  logic                                  cam_en_in,
    input  logic [NUM_ENTRY-1:0]                  read_entry_addr_decoded_in,
    input  logic [NUM_ENTRY-1:0]                  write_entry_addr_decoded_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] cam_entry_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] write_entry_in,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] read_entry_out,
    output logic [NUM_ENTRY-1:0]                  cam_result_decoded_out
);

    localparam int W = SINGLE_ENTRY_WIDTH_IN_BITS;
    localparam int N = NUM_ENTRY;

    // Storage and registered port outputs
    logic [N-1:0][W-1:0] entry_q;
    logic [N-1:0][W-1:0] entry_d;
    logic [W-1:0]        read_entry_q;
    logic [W-1:0]        read_entry_d;
    logic [N-1:0]        cam_result_q;
    logic [N-1:0]        cam_result_d;

    // Per-entry full-width compare against the search key
    logic [N-1:0]        w_match;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cam_cmp
            assign w_match[gi] = (entry_q[gi] == cam_entry_in);
        end
    endgenerate

    // Write: every entry selected by the mask loads the write data
    always_comb begin
        entry_d = entry_q;
        if (write_en_in) begin
            for (int i = 0; i < N; i++) begin
                if (write_entry_addr_decoded_in[i]) begin
                    entry_d[i] = write_entry_in;
                end
            end
        end
    end

    // Read: OR of all selected entries (pre-write contents); hold when idle
    always_comb begin
        read_entry_d = read_entry_q;
        if (read_en_in) begin
            read_entry_d = '0;
            for (int i = 0; i < N; i++) begin
                if (read_entry_addr_decoded_in[i]) begin
                    read_entry_d = read_entry_d | entry_q[i];
                end
            end
        end
    end

    // CAM: capture the match vector when enabled, otherwise hold
    always_comb begin
        cam_result_d = cam_result_q;
        if (cam_en_in) begin
            cam_result_d = w_match;
        end
    end

    // State update; reset clears the array and both outputs immediately
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            entry_q      <= '0;
            read_entry_q <= '0;
            cam_result_q <= '0;
        end else begin
            entry_q      <= entry_d;
            read_entry_q <= read_entry_d;
            cam_result_q <= cam_result_d;
        end
    end

    assign read_entry_out         = read_entry_q;
    assign cam_result_decoded_out = cam_result_q;

endmodule
`default_nettype wire

// File: tb/tb_tri_port_cam_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tri_port_cam_regfile
//  Description : Scoreboard bench for tri_port_cam_regfile (W=8, N=4).
//                Directed scenarios followed by random traffic; expected
//                outputs come from an array-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tri_port_cam_regfile;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk_in = 1'b0;
    logic         reset_in;
    logic         read_en_in, write_en_in, cam_en_in;
    logic [N-1:0] read_entry_addr_decoded_in, write_entry_addr_decoded_in;
    logic [W-1:0] cam_entry_in, write_entry_in;
    logic [W-1:0] read_entry_out;
    logic [N-1:0] cam_result_decoded_out;

    tri_port_cam_regfile #(
        .SINGLE_ENTRY_WIDTH_IN_BITS(W),
        .NUM_ENTRY                 (N)
    ) dut (
        .clk_in                     (clk_in),
        .reset_in                   (reset_in),
        .read_en_in                 (read_en_in),
        .write_en_in                (write_en_in),
        .cam_en_in                  (cam_en_in),
        .read_entry_addr_decoded_in (read_entry_addr_decoded_in),
        .write_entry_addr_decoded_in(write_entry_addr_decoded_in),
        .cam_entry_in               (cam_entry_in),
        .write_entry_in             (write_entry_in),
        .read_entry_out             (read_entry_out),
        .cam_result_decoded_out     (cam_result_decoded_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [W-1:0] rd;
        logic [N-1:0] cam;
    } exp_t;

    exp_t         exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    // Reference model: plain array of entries plus the last results
    logic [W-1:0] m_ent [N];
    logic [W-1:0] m_rd;
    logic [N-1:0] m_cam;

    task automatic check_rd(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: read_entry_out got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_cam(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: cam_result got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_ent[i] = '0;
        m_rd  = '0;
        m_cam = '0;
    endtask

    // One clock of stimulus: drive away from the edge, predict, enqueue
    task automatic step(input logic re, input logic we, input logic ce,
                        input logic [N-1:0] ra, input logic [N-1:0] wm,
                        input logic [W-1:0] key, input logic [W-1:0] wd);
        exp_t e;
        logic [W-1:0] acc;
        @(negedge clk_in);
        read_en_in                  = re;
        write_en_in                 = we;
        cam_en_in                   = ce;
        read_entry_addr_decoded_in  = ra;
        write_entry_addr_decoded_in = wm;
        cam_entry_in                = key;
        write_entry_in              = wd;
        if (re) begin
            acc = '0;
            for (int i = 0; i < N; i++) if (ra[i]) acc = acc | m_ent[i];
            m_rd = acc;
        end
        if (ce) begin
            for (int i = 0; i < N; i++) m_cam[i] = (m_ent[i] == key);
        end
        if (we) begin
            for (int i = 0; i < N; i++) if (wm[i]) m_ent[i] = wd;
        end
        e.rd  = m_rd;
        e.cam = m_cam;
        exp_q.push_back(e);
        @(posedge clk_in);
    endtask

    // Monitor: after every edge, pop the prediction for that edge and compare
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_rd ("sb_read", read_entry_out, e.rd);
                check_cam("sb_cam",  cam_result_decoded_out, e.cam);
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] ra, wm;
        logic [W-1:0] key;
        reset_in = 1'b1;
        read_en_in = 0; write_en_in = 0; cam_en_in = 0;
        read_entry_addr_decoded_in = '0; write_entry_addr_decoded_in = '0;
        cam_entry_in = '0; write_entry_in = '0;
        model_reset();
        #17;
        @(negedge clk_in);
        reset_in = 1'b0;
        check_rd ("reset_read", read_entry_out, 8'h00);
        check_cam("reset_cam",  cam_result_decoded_out, 4'b0000);

        // 3. CAM after reset: entries are zero, key F0 matches nothing
        step(0, 0, 1, 4'b0000, 4'b0000, 8'hF0, 8'h00);
        // 1. write F0 to entry 0, then read it
        step(0, 1, 0, 4'b0000, 4'b0001, 8'h00, 8'hF0);
        step(1, 0, 0, 4'b0001, 4'b0000, 8'h00, 8'h00);
        // 2. read+write together, then change write data with write disabled
        step(1, 1, 0, 4'b0001, 4'b0001, 8'h00, 8'hF0);
        step(1, 0, 0, 4'b0001, 4'b0000, 8'h00, 8'h0F);
        step(1, 0, 0, 4'b0001, 4'b0000, 8'h00, 8'h0F);
        // hold with read disabled, and all-zero read address
        step(0, 0, 0, 4'b0001, 4'b0000, 8'h00, 8'h00);
        step(1, 0, 0, 4'b0000, 4'b0000, 8'h00, 8'h00);
        // 4. broadcast write, CAM all match
        step(0, 1, 0, 4'b0000, 4'b1111, 8'h00, 8'hF0);
        step(0, 0, 1, 4'b0000, 4'b0000, 8'hF0, 8'h00);
        // 5. partial overwrite, CAM and read entry 1; CAM hold when disabled
        step(0, 1, 0, 4'b0000, 4'b1010, 8'h00, 8'h0F);
        step(1, 0, 1, 4'b0010, 4'b0000, 8'hF0, 8'h00);
        step(0, 0, 0, 4'b0000, 4'b0000, 8'h0F, 8'h00);
        // empty write mask is a no-op; multi-bit read ORs entries
        step(0, 1, 0, 4'b0000, 4'b0000, 8'h00, 8'h33);
        step(1, 0, 1, 4'b0011, 4'b0000, 8'h0F, 8'h00);
        // 6. same-edge write/read of entry 2 returns old, then new
        step(1, 1, 1, 4'b0100, 4'b0100, 8'hAA, 8'hAA);
        step(1, 0, 1, 4'b0100, 4'b0000, 8'hAA, 8'h00);

        // async reset between edges clears outputs at once; a write held
        // across an edge during reset must not land
        @(negedge clk_in);
        #1;
        reset_in = 1'b1;
        #1;
        check_rd ("async_reset_read", read_entry_out, 8'h00);
        check_cam("async_reset_cam",  cam_result_decoded_out, 4'b0000);
        model_reset();
        write_en_in = 1'b1; write_entry_addr_decoded_in = 4'b1111; write_entry_in = 8'h55;
        @(posedge clk_in);
        @(negedge clk_in);
        reset_in = 1'b0;
        write_en_in = 1'b0;
        step(1, 0, 1, 4'b1111, 4'b0000, 8'h00, 8'h00);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            ra  = ($urandom_range(0, 1) == 1) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
            wm  = ($urandom_range(0, 1) == 1) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
            key = ($urandom_range(0, 2) != 0) ? m_ent[$urandom_range(0, 3)] : 8'($urandom);
            step(1'($urandom), 1'($urandom), 1'($urandom), ra, wm, key,
                 ($urandom_range(0, 3) == 0) ? 8'hF0 : 8'($urandom));
        end

        @(negedge clk_in);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: pending %0d expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
